// File: rtl/lift_pkg.sv
// -----------------------------------------------------------------------------
// lift_pkg
// Shared definitions for the lift controller: hall-call request codes, the
// button-index-to-code mapping, button index constants and the direction
// encoding used by the lift FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package lift_pkg;

    // Request codes presented to the lift FSM
    localparam logic [2:0] _NONE = 3'b000;
    localparam logic [2:0] _1U   = 3'b001;
    localparam logic [2:0] _2U   = 3'b010;
    localparam logic [2:0] _3U   = 3'b011;
    localparam logic [2:0] _4D   = 3'b100;
    localparam logic [2:0] _2D   = 3'b110;
    localparam logic [2:0] _3D   = 3'b111;

    // Hall-call button indices into btn / pending
    localparam int BTN_1U = 0;
    localparam int BTN_2U = 1;
    localparam int BTN_3U = 2;
    localparam int BTN_2D = 3;
    localparam int BTN_3D = 4;
    localparam int BTN_4D = 5;
    localparam int NUM_BTN = 6;

    // Direction outputs of the lift FSM
    typedef enum logic [1:0] {
        UP   = 2'b00,
        DOWN = 2'b01,
        STAY = 2'b10
    } dir_e;

    // Button index -> request code
    function automatic logic [2:0] code_of(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = _1U;
            3'd1:    code = _2U;
            3'd2:    code = _3U;
            3'd3:    code = _2D;
            3'd4:    code = _3D;
            3'd5:    code = _4D;
            default: code = _NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/lift_request_queue_if.sv
// -----------------------------------------------------------------------------
// lift_request_queue_if
// Request handshake between the hall-call queue and the lift FSM.
//   btn     : one-cycle button press pulses (6)
//   done    : FSM idle and consuming din this cycle
//   din     : head request code, NONE when empty (3)
//   q_empty : queue holds no entries
//   pending : per-button lamp (6)
// master = queue side, slave = FSM / button side.
// -----------------------------------------------------------------------------
interface lift_request_queue_if;
    logic [5:0] btn;
    logic       done;
    logic [2:0] din;
    logic       q_empty;
    logic [5:0] pending;

    modport master (
        input  btn,
        input  done,
        output din,
        output q_empty,
        output pending
    );

    modport slave (
        output btn,
        output done,
        input  din,
        input  q_empty,
        input  pending
    );
endinterface

// File: rtl/lift_req_fifo.sv
// -----------------------------------------------------------------------------
// lift_req_fifo
// Generic synchronous FIFO of 3-bit request codes.
//   clk, rst_n : clock, synchronous active-low reset
//   push_i     : write data_i at the tail
//   pop_i      : drop the head (ignored when empty)
//   data_i     : code to push (3)
//   head_o     : head entry, 000 when empty (3)
//   empty_o    : no entries held
//   count_o    : number of entries (PTR_W+1)
// DEPTH must be >= 6 and 2**PTR_W >= DEPTH.
// -----------------------------------------------------------------------------
module lift_req_fifo #(
    parameter int DEPTH = 6,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [2:0]       data_i,
    output logic [2:0]       head_o,
    output logic             empty_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [2:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop_eff;

    assign pop_eff = pop_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_eff) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        case ({push_i, pop_eff})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: stale entries are never visible because the
    // head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : 3'b000;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Dedup upstream bounds occupancy; a push while full means that broke.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        push_i |-> (count_q != FULL_CNT));

endmodule

// File: rtl/lift_request_queue.sv
// -----------------------------------------------------------------------------
// lift_request_queue
// Collects hall-call presses, suppresses duplicates of requests already
// latched or queued, and serialises them in arrival order to the lift FSM.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : lift_request_queue_if.master (btn, done in; din, q_empty,
//                pending out)
// -----------------------------------------------------------------------------
module lift_request_queue
    import lift_pkg::*;
#(
    parameter int DEPTH = 6,
    parameter int PTR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lift_request_queue_if.master  bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [5:0]     req_lat_q, req_lat_d;   // pressed, not yet pushed
    logic [5:0]     inq_q, inq_d;           // code resident in the FIFO
    logic [5:0]     pop_mask;               // one-hot of the code being popped
    logic [5:0]     inq_after_pop;
    logic [5:0]     accept;
    logic [5:0]     push_mask;              // lowest latched request
    logic [2:0]     push_code;
    logic           push;
    logic           pop;
    logic [2:0]     fifo_head;
    logic           fifo_empty;
    logic [PTR_W:0] fifo_count;

    assign pop  = bus.done && !fifo_empty;
    assign push = |req_lat_q;

    // Codes are distinct per button, so at most one bit of pop_mask is set.
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_pop_mask
        assign pop_mask[gi] = pop && (fifo_head == code_of(3'(gi)));
    end

    // A press on the code being popped this cycle is accepted, so the
    // duplicate check uses the post-pop residency.
    assign inq_after_pop = inq_q & ~pop_mask;
    assign accept        = bus.btn & ~req_lat_q & ~inq_after_pop;

    // Isolate the lowest set bit: fixed priority, lower index first.
    assign push_mask = req_lat_q & (~req_lat_q + 6'd1);

    always_comb begin
        push_code = _NONE;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (req_lat_q[i]) begin
                push_code = code_of(3'(i));
            end
        end
    end

    // A pushed bit was latched (so not in the FIFO) and an accepted bit was
    // not latched, so these updates never collide on the same button.
    assign req_lat_d = (req_lat_q & ~push_mask) | accept;
    assign inq_d     = inq_after_pop | push_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_lat_q <= '0;
            inq_q     <= '0;
        end else begin
            req_lat_q <= req_lat_d;
            inq_q     <= inq_d;
        end
    end

    lift_req_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_code),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.din     = fifo_head;
    assign bus.q_empty = fifo_empty;
    assign bus.pending = req_lat_q | inq_q;

    a_lat_inq_disjoint: assert property (@(posedge clk) disable iff (!rst_n)
        (req_lat_q & inq_q) == 6'b0);

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= FULL_CNT);

endmodule

// File: tb/tb_lift_request_queue.sv
// -----------------------------------------------------------------------------
// tb_lift_request_queue
// Directed scenarios followed by randomized presses, pops and resets. Outputs
// are compared every cycle against a reference model holding the queue as a
// list of codes and the not-yet-queued presses as a set of buttons.
// -----------------------------------------------------------------------------
module tb_lift_request_queue;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lift_request_queue_if bus_if ();

    lift_request_queue #(
        .DEPTH (6),
        .PTR_W (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    int m_fifo[$];
    bit m_wait[6];
    int CODES[6] = '{1, 2, 3, 6, 7, 4};

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit in_fifo(input int code);
        foreach (m_fifo[k]) begin
            if (m_fifo[k] == code) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock edge of the behavioural model.
    task automatic model_step(input bit r, input logic [5:0] b, input bit d);
        int cand;
        bit acc[6];
        if (!r) begin
            m_fifo.delete();
            foreach (m_wait[i]) m_wait[i] = 1'b0;
            return;
        end
        // Oldest-by-priority waiting request is queued this edge.
        cand = -1;
        for (int i = 0; i < 6; i++) begin
            if (m_wait[i] && cand < 0) cand = i;
        end
        if (d && m_fifo.size() > 0) void'(m_fifo.pop_front());
        // A press counts if the request is neither waiting nor still queued.
        for (int i = 0; i < 6; i++) begin
            acc[i] = b[i] && !m_wait[i] && !in_fifo(CODES[i]);
        end
        if (cand >= 0) begin
            m_fifo.push_back(CODES[cand]);
            m_wait[cand] = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            if (acc[i]) m_wait[i] = 1'b1;
        end
    endtask

    function automatic int exp_pending();
        int p;
        p = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_wait[i] || in_fifo(CODES[i])) p |= (1 << i);
        end
        return p;
    endfunction

    // Apply inputs for one cycle, advance the model at the edge, and compare
    // outputs at the following falling edge.
    task automatic cycle(input bit r, input logic [5:0] b, input bit d);
        rst_n       = r;
        bus_if.btn  = b;
        bus_if.done = d;
        @(posedge clk);
        model_step(r, b, d);
        @(negedge clk);
        cyc++;
        bus_if.btn  = 6'b0;
        $display("cyc %0d rst_n=%b btn=%b done=%b -> din=%0d q_empty=%b pending=%b",
                 cyc, r, b, d, bus_if.din, bus_if.q_empty, bus_if.pending);
        check_val("din",     int'(bus_if.din),     (m_fifo.size() > 0) ? m_fifo[0] : 0);
        check_val("q_empty", int'(bus_if.q_empty), (m_fifo.size() == 0) ? 1 : 0);
        check_val("pending", int'(bus_if.pending), exp_pending());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] rb;
        bit         rr;
        bit         rd;

        rst_n       = 1'b0;
        bus_if.btn  = 6'b0;
        bus_if.done = 1'b0;
        @(negedge clk);

        // Reset then idle with done held high
        cycle(1'b0, 6'b0, 1'b1);
        cycle(1'b0, 6'b0, 1'b1);
        check_val("rst_q_empty", int'(bus_if.q_empty), 1);
        check_val("rst_pending", int'(bus_if.pending), 0);
        repeat (2) cycle(1'b1, 6'b0, 1'b1);

        // Single 3U call
        cycle(1'b1, 6'b000100, 1'b0);
        check_val("3u_lamp",  int'(bus_if.pending[2]), 1);
        check_val("3u_empty", int'(bus_if.q_empty),     1);
        cycle(1'b1, 6'b0, 1'b0);
        check_val("3u_din",   int'(bus_if.din),         3);
        cycle(1'b1, 6'b0, 1'b1);
        check_val("3u_popped", int'(bus_if.q_empty),    1);

        // Simultaneous 1U + 4D: lower index first
        cycle(1'b1, 6'b100001, 1'b0);
        repeat (3) cycle(1'b1, 6'b0, 1'b0);
        check_val("sim_head1", int'(bus_if.din), 1);
        cycle(1'b1, 6'b0, 1'b1);
        check_val("sim_head2", int'(bus_if.din), 4);
        cycle(1'b1, 6'b0, 1'b1);
        check_val("sim_head3", int'(bus_if.din), 0);

        // Duplicate 2D while queued
        cycle(1'b1, 6'b001000, 1'b0);
        repeat (4) cycle(1'b1, 6'b0, 1'b0);
        cycle(1'b1, 6'b001000, 1'b0);
        repeat (2) cycle(1'b1, 6'b0, 1'b0);
        cycle(1'b1, 6'b0, 1'b1);
        check_val("dup_empty", int'(bus_if.q_empty), 1);

        // Pop and re-press 3D in the same cycle
        cycle(1'b1, 6'b010000, 1'b0);
        cycle(1'b1, 6'b0, 1'b0);
        cycle(1'b1, 6'b010000, 1'b1);
        check_val("repress_lamp", int'(bus_if.pending[4]), 1);
        cycle(1'b1, 6'b0, 1'b0);
        check_val("repress_din",  int'(bus_if.din), 7);
        cycle(1'b1, 6'b0, 1'b1);
        check_val("repress_one",  int'(bus_if.q_empty), 1);

        // Fill, pop two with re-press (wrap-around), pop two, reset with 4 queued
        cycle(1'b1, 6'b111111, 1'b0);
        repeat (7) cycle(1'b1, 6'b0, 1'b0);
        cycle(1'b1, 6'b000001, 1'b1);
        cycle(1'b1, 6'b000010, 1'b1);
        repeat (3) cycle(1'b1, 6'b0, 1'b0);
        cycle(1'b1, 6'b0, 1'b1);
        cycle(1'b1, 6'b0, 1'b1);
        check_val("fill_head", int'(bus_if.din), 7);
        cycle(1'b0, 6'b0, 1'b0);
        check_val("midrst_empty",   int'(bus_if.q_empty), 1);
        check_val("midrst_pending", int'(bus_if.pending), 0);
        check_val("midrst_din",     int'(bus_if.din),     0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 79) != 0);
            rb = 6'($urandom);
            if ($urandom_range(0, 2) != 0) rb = 6'b0;
            rd = ($urandom_range(0, 2) == 0);
            cycle(rr, rb, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
